// File: rtl/window_stream_gen_if.sv
// Stream bundle between a raster pixel source and window_stream_gen:
// pixels with start-of-frame in, KxK neighbourhood windows with strobes out.
interface window_stream_gen_if #(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3
);
    logic [NBIT-1:0] i_pixel;
    logic            i_pixel_valid;
    logic            i_sof;
    logic [NBIT-1:0] o_data [KERNEL_SIZE][KERNEL_SIZE];
    logic            o_data_valid;
    logic            o_eof;

    modport master (
        output i_pixel, i_pixel_valid, i_sof,
        input  o_data, o_data_valid, o_eof
    );

    modport slave (
        input  i_pixel, i_pixel_valid, i_sof,
        output o_data, o_data_valid, o_eof
    );
endinterface

// File: rtl/window_stream_gen.sv
// Raster pixel stream to KERNEL_SIZE x KERNEL_SIZE window stream using
// KERNEL_SIZE-1 line buffers and a window shift register; no edge padding.
module window_stream_gen #(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    window_stream_gen_if.slave bus
);
    localparam int K  = KERNEL_SIZE;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef logic [NBIT-1:0] pix_t;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          accept;
    logic          valid_q, valid_d;
    logic          eof_q, eof_d;

    pix_t line_q [K-1][IMG_WIDTH];
    pix_t win_q  [K][K];
    pix_t win_d  [K][K];

    // A start-of-frame pixel is forced to (0,0) whatever the counters say.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        accept  = bus.i_pixel_valid;
        cur_col = bus.i_sof ? '0 : col_q;
        cur_row = bus.i_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        eof_d   = 1'b0;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            valid_d = (cur_row >= ROW_WIN) && (cur_col >= COL_WIN);
            eof_d   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end
    end

    // Window: shift left, newest column is the current pixel under the stacked older rows.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
            end
            win_d[K-1][K-1] = bus.i_pixel;
            for (int k = 0; k < K - 1; k++) begin
                win_d[K-2-k][K-1] = line_q[k][cur_col];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
            win_q   <= win_d;
        end
    end

    // NOTE: line storage is deliberately not reset; row/col masking keeps stale entries out of valid windows, so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            line_q[0][cur_col] <= bus.i_pixel;
            for (int k = 0; k < K - 2; k++) begin
                line_q[k+1][cur_col] <= line_q[k][cur_col];
            end
        end
    end

    assign bus.o_data       = win_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_eof        = eof_q;

endmodule
